// File: rtl/mem_port_arbiter_if.sv
// Bus between the two requesters/memory and the port arbiter.
// Requests are level signals held until the matching one-cycle ack; mem_ready completes an access.
interface mem_port_arbiter_if;
  logic req0;
  logic req1;
  logic we1;
  logic mem_ready;
  logic sel;
  logic mem_req;
  logic mem_we;
  logic ack0;
  logic ack1;
  logic busy;
  logic timeout_err;

  // master: requesters plus memory side; slave: the arbiter itself.
  modport master (
    output req0, req1, we1, mem_ready,
    input  sel, mem_req, mem_we, ack0, ack1, busy, timeout_err
  );

  modport slave (
    input  req0, req1, we1, mem_ready,
    output sel, mem_req, mem_we, ack0, ack1, busy, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit memory port between instruction fetch (req0) and data access (req1),
// with round-robin or fixed-priority grant and an ACCESS stall watchdog.
module mem_port_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 16,
  parameter int CW         = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus,
  output logic [1:0]           o_dbg_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_last_grant;
  logic          r_sel;
  logic          r_mem_req;
  logic          r_mem_we;
  logic          r_ack0;
  logic          r_ack1;
  logic          r_busy;
  logic          r_timeout_err;

  logic          w_any_req;
  logic          w_winner;

  assign w_any_req = bus.req0 | bus.req1;

  // On a tie, round-robin hands the port to whoever did not win last time.
  assign w_winner = (bus.req0 & bus.req1) ? ((FIXED_PRIO != 0) ? 1'b1 : ~r_last_grant)
                                          : bus.req1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_last_grant  <= 1'b1;
      r_sel         <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state      <= ST_ACCESS;
            r_sel        <= w_winner;
            r_last_grant <= w_winner;
            r_mem_req    <= 1'b1;
            r_mem_we     <= w_winner & bus.we1;
            r_busy       <= 1'b1;
            r_cnt        <= '0;
          end
        end
        ST_ACCESS: begin
          if (bus.mem_ready) begin
            // sel still names the granted requester, so it picks the ack line.
            r_state   <= ST_ACK;
            r_ack0    <= ~r_sel;
            r_ack1    <= r_sel;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_state       <= ST_IDLE;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel         = r_sel;
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_we      = r_mem_we;
  assign bus.ack0        = r_ack0;
  assign bus.ack1        = r_ack1;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_timeout_err;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin and a fixed-priority instance share one stimulus
// stream and are compared every cycle against a transaction-level model, plus literal checks.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic req0, req1, we1, mem_ready;

  always #5 clk = ~clk;

  mem_port_arbiter_if ifc_rr();
  mem_port_arbiter_if ifc_fp();

  assign ifc_rr.req0 = req0;
  assign ifc_rr.req1 = req1;
  assign ifc_rr.we1 = we1;
  assign ifc_rr.mem_ready = mem_ready;
  assign ifc_fp.req0 = req0;
  assign ifc_fp.req1 = req1;
  assign ifc_fp.we1 = we1;
  assign ifc_fp.mem_ready = mem_ready;

  logic [1:0] dbg_rr, dbg_fp;

  mem_port_arbiter #(.FIXED_PRIO(0), .TIMEOUT(TIMEOUT), .CW(5)) dut_rr (
    .clk(clk), .rst_n(rst_n), .bus(ifc_rr), .o_dbg_state(dbg_rr)
  );

  mem_port_arbiter #(.FIXED_PRIO(1), .TIMEOUT(TIMEOUT), .CW(5)) dut_fp (
    .clk(clk), .rst_n(rst_n), .bus(ifc_fp), .o_dbg_state(dbg_fp)
  );

  // {sel, mem_req, mem_we, ack0, ack1, busy, timeout_err}
  logic [6:0] dut_out [2];
  assign dut_out[0] = {ifc_rr.sel, ifc_rr.mem_req, ifc_rr.mem_we, ifc_rr.ack0,
                       ifc_rr.ack1, ifc_rr.busy, ifc_rr.timeout_err};
  assign dut_out[1] = {ifc_fp.sel, ifc_fp.mem_req, ifc_fp.mem_we, ifc_fp.ack0,
                       ifc_fp.ack1, ifc_fp.busy, ifc_fp.timeout_err};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 = waiting for a request, 1 = memory access in flight, 2 = acknowledging
  int   m_phase [2] = '{0, 0};
  int   m_wait  [2] = '{0, 0};
  logic m_grant [2] = '{1'b0, 1'b0};
  logic m_last  [2] = '{1'b1, 1'b1};
  logic m_sel   [2] = '{1'b0, 1'b0};
  logic m_we    [2] = '{1'b0, 1'b0};
  logic m_terr  [2] = '{1'b0, 1'b0};
  logic [0:0] exp_q0[$];
  logic [0:0] exp_q1[$];

  task automatic model_step(input int k);
    logic w;
    case (m_phase[k])
      0: if (req0 || req1) begin
        if (req0 && req1) w = (k == 1) ? 1'b1 : !m_last[k];
        else              w = req1;
        m_phase[k] = 1;
        m_grant[k] = w;
        m_last[k]  = w;
        m_sel[k]   = w;
        m_we[k]    = w && we1;
        m_wait[k]  = 0;
      end
      1: if (mem_ready) begin
        m_phase[k] = 2;
        if (k == 0) exp_q0.push_back(m_grant[k]);
        else        exp_q1.push_back(m_grant[k]);
      end else if (m_wait[k] == TIMEOUT - 1) begin
        m_phase[k] = 0;
        m_terr[k]  = 1'b1;
      end else begin
        m_wait[k]++;
      end
      default: m_phase[k] = 0;
    endcase
  endtask

  function automatic logic [6:0] model_out(input int k);
    return {m_sel[k], m_phase[k] == 1, m_phase[k] == 1 && m_grant[k] && m_we[k],
            m_phase[k] == 2 && !m_grant[k], m_phase[k] == 2 && m_grant[k],
            m_phase[k] != 0, m_terr[k]};
  endfunction

  task automatic scoreboard_ack(input int k);
    logic [0:0] got;
    if (dut_out[k][3] | dut_out[k][2]) begin
      if (k == 0) begin
        if (exp_q0.size() == 0) check("ack_unexpected_rr", 1, 0);
        else begin got = exp_q0.pop_front(); check("ack_id_rr", 32'(dut_out[0][2]), 32'(got)); end
      end else begin
        if (exp_q1.size() == 0) check("ack_unexpected_fp", 1, 0);
        else begin got = exp_q1.pop_front(); check("ack_id_fp", 32'(dut_out[1][2]), 32'(got)); end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_phase[k] = 0; m_wait[k] = 0; m_sel[k] = 1'b0;
        m_last[k] = 1'b1; m_terr[k] = 1'b0; m_we[k] = 1'b0;
      end
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      for (int k = 0; k < 2; k++) model_step(k);
      #1;
      for (int k = 0; k < 2; k++) begin
        check($sformatf("outputs_dut%0d", k), 32'(dut_out[k]), 32'(model_out(k)));
        scoreboard_ack(k);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic g_seq [2][8];
  int   g_n   [2];
  logic prev_req [2];
  int   cnt;
  int   ack0_fp_cnt;
  int   stuck;

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we1 = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out_rr", 32'(dut_out[0]), 32'h0);
    check("reset_out_fp", 32'(dut_out[1]), 32'h0);
    rst_n = 1'b1;

    // single fetch, memory ready at once
    @(negedge clk);
    req0 = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    check("fetch_c1_sel", 32'(ifc_rr.sel), 0);
    check("fetch_c1_mem_req", 32'(ifc_rr.mem_req), 1);
    @(negedge clk);
    check("fetch_c2_ack0", 32'(ifc_rr.ack0), 1);
    check("fetch_c2_mem_req", 32'(ifc_rr.mem_req), 0);
    req0 = 1'b0;
    @(negedge clk);
    check("fetch_c3_busy", 32'(ifc_rr.busy), 0);

    // tie held: round-robin alternates, fixed priority always serves data
    do_reset();
    req0 = 1'b1; req1 = 1'b1; mem_ready = 1'b1;
    g_n = '{0, 0}; prev_req = '{1'b0, 1'b0}; ack0_fp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (dut_out[k][5] && !prev_req[k] && g_n[k] < 8) begin
          g_seq[k][g_n[k]] = dut_out[k][6];
          g_n[k]++;
        end
        prev_req[k] = dut_out[k][5];
      end
      ack0_fp_cnt += int'(ifc_fp.ack0);
    end
    req0 = 1'b0; req1 = 1'b0;
    check("rr_grant_count", 32'(g_n[0]), 4);
    check("fp_grant_count", 32'(g_n[1]), 4);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("rr_grant_%0d", j), 32'(g_seq[0][j]), 32'(j % 2));
      check($sformatf("fp_grant_%0d", j), 32'(g_seq[1][j]), 1);
    end
    check("fp_ack0_never", 32'(ack0_fp_cnt), 0);
    repeat (2) @(negedge clk);

    // data write with three wait cycles; we1 dropped mid-access
    req1 = 1'b1; we1 = 1'b1; mem_ready = 1'b0; cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      cnt += int'(ifc_rr.mem_we);
      if (i == 1) we1 = 1'b0;
      if (i == 4) mem_ready = 1'b1;
      if (i == 5) begin
        check("write_ack1", 32'(ifc_rr.ack1), 1);
        req1 = 1'b0;
      end
    end
    check("write_mem_we_cycles", 32'(cnt), 4);

    // watchdog: memory never ready
    req0 = 1'b1; mem_ready = 1'b0; cnt = 0;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      cnt += int'(ifc_rr.mem_req);
      if (i == 17) begin
        check("timeout_mem_req_low", 32'(ifc_rr.mem_req), 0);
        check("timeout_err_set", 32'(ifc_rr.timeout_err), 1);
        check("timeout_no_ack0", 32'(ifc_rr.ack0), 0);
      end
    end
    check("timeout_mem_req_cycles", 32'(cnt), TIMEOUT);
    @(negedge clk);
    check("timeout_regrant", 32'({ifc_rr.mem_req, ifc_rr.sel}), 32'h2);
    mem_ready = 1'b1; req0 = 1'b0;
    @(negedge clk);
    check("timeout_retry_ack0", 32'(ifc_rr.ack0), 1);
    @(negedge clk);
    check("timeout_err_sticky", 32'(ifc_rr.timeout_err), 1);

    // randomized traffic, with occasional long memory stalls
    stuck = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req0 = ~req0;
      if ($urandom_range(0, 3) == 0) req1 = ~req1;
      we1 = 1'($urandom_range(0, 1));
      if (stuck > 0) begin
        stuck--;
        mem_ready = 1'b0;
      end else begin
        if ($urandom_range(0, 99) < 2) stuck = 20;
        mem_ready = ($urandom_range(0, 2) != 0);
      end
    end

    // asynchronous reset in the middle of a data access
    req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    req1 = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    check("pre_reset_access", 32'({ifc_rr.sel, ifc_rr.mem_req}), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_rr", 32'(dut_out[0]), 32'h0);
    check("async_reset_fp", 32'(dut_out[1]), 32'h0);
    rst_n = 1'b1;
    req0 = 1'b1; req1 = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    check("post_reset_tie_rr", 32'({ifc_rr.sel, ifc_rr.mem_req}), 32'h1);
    check("post_reset_tie_fp", 32'({ifc_fp.sel, ifc_fp.mem_req}), 32'h3);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter that shares one 32-bit memory port between instruction fetch (requester 0) and the MEM-stage data access (requester 1).
- Drives the select of the 32-bit 2:1 address/data mux: sel=0 passes in1 (fetch), sel=1 passes in2 (data).
- Sequences the memory handshake and returns a one-cycle acknowledge to the winning requester.
- Includes round-robin or fixed-priority grant and a stall-timeout watchdog.

Parameters:
- FIXED_PRIO, 0; 0 = round-robin between requesters, 1 = requester 1 (data) always wins a tie.
- TIMEOUT, 16; maximum ACCESS cycles allowed without mem_ready before the transaction is aborted. Must be 2..2^CW-1.
- CW, 5; width of the timeout counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  fetch request, level; held until ack0.
- req1  input  1  data request, level; held until ack1.
- we1  input  1  write enable for requester 1, sampled at grant.
- mem_ready  input  1  memory completion, sampled each ACCESS cycle.
- sel  output  1  mux select (0 = in1/fetch, 1 = in2/data), registered.
- mem_req  output  1  memory request, high throughout ACCESS.
- mem_we  output  1  memory write strobe, high in ACCESS only for a granted requester-1 write.
- ack0  output  1  one-cycle completion pulse to requester 0.
- ack1  output  1  one-cycle completion pulse to requester 1.
- busy  output  1  high in ACCESS or ACK.
- timeout_err  output  1  sticky; set on any aborted transaction, cleared only by reset.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; sel, mem_req, mem_we, ack0, ack1, busy, timeout_err all 0; cnt=0; last_grant=1 (so requester 0 wins the first tie).
- All outputs are registered.
- States: IDLE, ACCESS, ACK.
- IDLE, no request: stay in IDLE.
- IDLE, request present (either reqX=1):
  - Winner: only one requesting -> that one.
  - Both requesting, FIXED_PRIO=1 -> requester 1.
  - Both requesting, FIXED_PRIO=0 -> the requester not equal to last_grant.
  - Next edge: state=ACCESS, sel=winner, last_grant=winner, mem_req=1, mem_we=(winner==1)&we1, cnt=0.
- ACCESS with mem_ready=1:
  - Next edge: state=ACK, ackX=1 for the granted requester, mem_req=0, mem_we=0.
  - sel holds its value through ACK.
- ACCESS with mem_ready=0 and cnt<TIMEOUT-1: cnt increments; all outputs hold.
- ACCESS with mem_ready=0 and cnt==TIMEOUT-1 (abort):
  - Next edge: state=IDLE, mem_req=0, mem_we=0, timeout_err=1, no ack.
  - A requester still holding req re-arbitrates normally (retry).
- ACK: lasts exactly one cycle; req0/req1 are ignored; next edge: state=IDLE, ackX=0.
  - This gives requesters one cycle to drop req after seeing ack.
- Minimum transaction: 1 IDLE grant cycle + 1 ACCESS cycle + 1 ACK cycle = 3 cycles. Back-to-back grants occur every 3 cycles when mem_ready is already high.
- Requester drops req during ACCESS: ignored; the transaction completes and ack still pulses.
- we1 changes after grant: ignored; mem_we is latched at grant.
- sel changes only on the IDLE->ACCESS edge; it never toggles while mem_req=1.
- Reset asserted mid-ACCESS: mem_req and sel drop immediately (asynchronously); no ack is issued.

Test Plan:
- Reset, then req0=1 only, mem_ready=1 -> cycle 1 sel=0, mem_req=1; cycle 2 ack0=1, mem_req=0; cycle 3 IDLE, busy=0.
- FIXED_PRIO=0, req0=req1=1 held, each ack'd requester re-requests, mem_ready=1 -> grant order 0,1,0,1; sel sequence 0,1,0,1; one ack every 3 cycles.
- FIXED_PRIO=1, req0=req1=1 held -> three consecutive grants all to requester 1 (sel=1, ack1 pulses); ack0 never asserted.
- req1=1, we1=1, mem_ready low 3 cycles then high -> mem_we=1 for 4 ACCESS cycles; ack1 one cycle after mem_ready sampled high; we1 dropped mid-ACCESS has no effect.
- TIMEOUT=16, req0=1, mem_ready stuck 0 -> mem_req high exactly 16 cycles, then drops; timeout_err=1 and stays 1; no ack0; a new grant to 0 follows.
- rst_n pulsed low for 1 ns mid-ACCESS -> mem_req, sel, busy = 0 immediately, before the next clk edge; timeout_err=0; next tie goes to requester 0.
